cordic_sincos_frontend: RTL and testbench

Request/response front end for the CORDIC pipeline when it is used to compute sin/cos in circular rotation mode.
- Upstream side: accepts angles over a valid/ready handshake and folds them from [-π, π] into the CORDIC convergence range [-π/2, π/2].
- CORDIC side: issues each folded angle to the pipeline and receives the raw cos/sin result.
- Downstream side: undoes the fold on each result and buffers it in a FIFO so downstream backpressure never loses a pipeline result.

---
 rtl/cordic_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/cordic_sincos_frontend.sv | 185 ++++++++++++++++++
 tb/tb_cordic_sincos_frontend.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC core and its front ends: mode encoding,
// angle constants in Q3.30 and a real-to-fixed helper for parameter setup.
package cordic_pkg;

  // Rotation family selected on the CORDIC mode input
  typedef enum logic signed [1:0] {
    LINEAR     = 2'sb00,
    HYPERBOLIC = 2'sb11,
    CIRCULAR   = 2'sb01
  } e_cordic_mode;

  // pi and pi/2 in Q3.30
  localparam longint PI      = 64'sd3373259426;
  localparam longint HALF_PI = 64'sd1686629713;

  // Convert a real value to a fixed-point integer with frac_bits fractional bits
  function automatic longint to_fixed(input real value, input int frac_bits);
    return longint'(value * (2.0 ** frac_bits));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary pointers carrying a wrap bit. Pushes into a
// full FIFO and pops from an empty FIFO are ignored. The head entry is always
// visible on rdata_o.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count_o = wr_q - rd_q;
  assign do_push = push_i && (count_o != DEPTH_CNT);
  assign do_pop  = pop_i && (count_o != '0);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // Advance each pointer by one on an effective push/pop
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array, data only, never reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cordic_sincos_frontend.sv
// sin/cos front end for a circular-rotation CORDIC. Requests are clamped to
// [-pi, pi], folded into [-pi/2, pi/2] and issued; a tag FIFO remembers the
// fold so each returning result can be unfolded and parked in a result FIFO.
// A credit counter bounds outstanding work to the result FIFO depth so a
// pipeline result never finds the result FIFO full.
module cordic_sincos_frontend
  import cordic_pkg::*;
#(
  parameter int N_ITERATION     = 12,
  parameter int INTEGER_BITS    = 3,
  parameter int FRACTIONAL_BITS = 30,
  parameter int BITS            = INTEGER_BITS + FRACTIONAL_BITS,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [BITS-1:0] s_angle,
  output logic                   c_valid,
  output logic signed [BITS-1:0] c_x,
  output logic signed [BITS-1:0] c_y,
  output logic signed [BITS-1:0] c_z,
  output logic [1:0]             c_mode,
  output logic                   c_rot_en,
  input  logic                   c_res_valid,
  input  logic signed [BITS-1:0] c_res_x,
  input  logic signed [BITS-1:0] c_res_y,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [BITS-1:0] m_cos,
  output logic signed [BITS-1:0] m_sin,
  output logic                   m_sat
);

  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RES_W = 2 * BITS + 1;

  localparam logic signed [BITS-1:0] PI_Q      = BITS'(PI);
  localparam logic signed [BITS-1:0] HALF_PI_Q = BITS'(HALF_PI);
  localparam logic [CW-1:0]          CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]          CREDIT_ONE = CW'(1);
  localparam logic [CNT_W-1:0]       DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_pow2
    $error("FIFO_DEPTH must be a power of two");
  end
  if (FIFO_DEPTH < N_ITERATION + 3) begin : g_depth_min
    $error("FIFO_DEPTH must cover the CORDIC latency plus issue and capture");
  end

  // Saturate an angle into [-pi, pi]
  function automatic logic signed [BITS-1:0] sat_angle(input logic signed [BITS-1:0] a);
    if (a > PI_Q)  return PI_Q;
    if (a < -PI_Q) return -PI_Q;
    return a;
  endfunction

  // Flag angles that sat_angle has to clamp
  function automatic logic is_sat(input logic signed [BITS-1:0] a);
    return (a > PI_Q) || (a < -PI_Q);
  endfunction

  // Two's complement negation when the angle was folded by pi
  function automatic logic signed [BITS-1:0] unfold(input logic signed [BITS-1:0] v,
                                                     input logic flip);
    return flip ? -v : v;
  endfunction

  logic signed [BITS-1:0] clamp_p0;
  logic signed [BITS-1:0] z_p0;
  logic                   sat_p0;
  logic                   flip_p0;
  logic                   s_acc;
  logic                   m_acc;

  logic                   vld_p1_q;
  logic signed [BITS-1:0] z_p1_q;

  logic [CW-1:0]          credit_q, credit_d;

  logic [1:0]             tag_rdata;
  logic [CNT_W-1:0]       tag_count;
  logic                   res_push;
  logic [RES_W-1:0]       res_wdata;
  logic [RES_W-1:0]       res_rdata;
  logic [CNT_W-1:0]       res_count;

  assign s_ready = (credit_q != '0);
  assign s_acc   = s_valid && s_ready;
  assign m_valid = (res_count != '0);
  assign m_acc   = m_valid && m_ready;

  // ---- stage p0: clamp and fold the accepted angle
  always_comb begin
    clamp_p0 = sat_angle(s_angle);
    sat_p0   = is_sat(s_angle);
    z_p0     = clamp_p0;
    flip_p0  = 1'b0;
    if (clamp_p0 > HALF_PI_Q) begin
      z_p0    = clamp_p0 - PI_Q;
      flip_p0 = 1'b1;
    end else if (clamp_p0 < -HALF_PI_Q) begin
      z_p0    = clamp_p0 + PI_Q;
      flip_p0 = 1'b1;
    end
  end

  // ---- stage p1: issue register, one c_valid pulse per accepted request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1_q <= 1'b0;
      z_p1_q   <= '0;
    end else begin
      vld_p1_q <= s_acc;
      if (s_acc) z_p1_q <= z_p0;
    end
  end

  assign c_valid  = vld_p1_q;
  assign c_z      = z_p1_q;
  assign c_x      = '0;
  assign c_y      = '0;
  assign c_mode   = CIRCULAR;
  assign c_rot_en = 1'b1;

  // Credits: one per free result slot, consumed on accept, returned on pop
  always_comb begin
    credit_d = credit_q;
    if (s_acc && !m_acc)      credit_d = credit_q - CREDIT_ONE;
    else if (m_acc && !s_acc) credit_d = credit_q + CREDIT_ONE;
  end

  // Credit register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) credit_q <= CREDIT_MAX;
    else          credit_q <= credit_d;
  end

  // Tag is written at accept so it is visible in the issue cycle
  sync_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (s_acc),
    .wdata_i ({flip_p0, sat_p0}),
    .pop_i   (res_push),
    .rdata_o (tag_rdata),
    .count_o (tag_count)
  );

  // ---- capture: results without a matching tag are stale and dropped
  assign res_push  = c_res_valid && (tag_count != '0);
  assign res_wdata = {tag_rdata[0],
                      unfold(c_res_x, tag_rdata[1]),
                      unfold(c_res_y, tag_rdata[1])};

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (res_push),
    .wdata_i (res_wdata),
    .pop_i   (m_acc),
    .rdata_o (res_rdata),
    .count_o (res_count)
  );

  // Head is masked while empty so stale storage never shows on the outputs
  assign m_sat = m_valid & res_rdata[RES_W-1];
  assign m_cos = m_valid ? res_rdata[2*BITS-1:BITS] : '0;
  assign m_sin = m_valid ? res_rdata[BITS-1:0]      : '0;

  a_res_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    res_push |-> (res_count != DEPTH_CNT));

  a_tag_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    s_acc |-> (tag_count != DEPTH_CNT));

endmodule

// File: tb/tb_cordic_sincos_frontend.sv
// Bench for cordic_sincos_frontend: a behavioural CORDIC with the core's
// latency sits on the c_* ports, a trig reference model produces expected
// results at accept time, and a monitor checks every output handshake.
module tb_cordic_sincos_frontend;
  import cordic_pkg::*;

  localparam int     N_ITERATION     = 12;
  localparam int     INTEGER_BITS    = 3;
  localparam int     FRACTIONAL_BITS = 30;
  localparam int     BITS            = INTEGER_BITS + FRACTIONAL_BITS;
  localparam int     FIFO_DEPTH      = 16;
  localparam real    SCALE           = 1073741824.0;
  localparam longint TOL             = 64'sd1048576;

  logic                   i_clk   = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic                   s_valid = 1'b0;
  logic                   s_ready;
  logic signed [BITS-1:0] s_angle = '0;
  logic                   c_valid;
  logic signed [BITS-1:0] c_x, c_y, c_z;
  logic [1:0]             c_mode;
  logic                   c_rot_en;
  logic                   c_res_valid;
  logic signed [BITS-1:0] c_res_x, c_res_y;
  logic                   m_valid;
  logic                   m_ready = 1'b0;
  logic signed [BITS-1:0] m_cos, m_sin;
  logic                   m_sat;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_results = 0;

  always #5 i_clk = ~i_clk;

  cordic_sincos_frontend #(
    .N_ITERATION     (N_ITERATION),
    .INTEGER_BITS    (INTEGER_BITS),
    .FRACTIONAL_BITS (FRACTIONAL_BITS),
    .BITS            (BITS),
    .FIFO_DEPTH      (FIFO_DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_angle     (s_angle),
    .c_valid     (c_valid),
    .c_x         (c_x),
    .c_y         (c_y),
    .c_z         (c_z),
    .c_mode      (c_mode),
    .c_rot_en    (c_rot_en),
    .c_res_valid (c_res_valid),
    .c_res_x     (c_res_x),
    .c_res_y     (c_res_y),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_cos       (m_cos),
    .m_sin       (m_sin),
    .m_sat       (m_sat)
  );

  // ---------------- behavioural CORDIC: N_ITERATION+1 cycle latency
  typedef struct packed {
    logic                   v;
    logic signed [BITS-1:0] x;
    logic signed [BITS-1:0] y;
  } cres_t;

  cres_t cpipe [N_ITERATION+1];

  function automatic cres_t cordic_eval(input logic v, input logic signed [BITS-1:0] z);
    cres_t r;
    real   zr;
    zr  = real'(longint'(z)) / SCALE;
    r.v = v;
    r.x = BITS'(longint'($cos(zr) * SCALE));
    r.y = BITS'(longint'($sin(zr) * SCALE));
    return r;
  endfunction

  always @(posedge i_clk) begin
    cpipe[0] <= cordic_eval(c_valid, c_z);
    for (int i = 1; i <= N_ITERATION; i++) cpipe[i] <= cpipe[i-1];
  end

  assign c_res_valid = cpipe[N_ITERATION].v;
  assign c_res_x     = cpipe[N_ITERATION].x;
  assign c_res_y     = cpipe[N_ITERATION].y;

  // ---------------- reference model and scoreboard
  typedef struct {
    longint c;
    longint s;
    bit     sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  function automatic exp_t ref_model(input longint ang);
    exp_t   e;
    longint a;
    real    r;
    a     = ang;
    e.sat = 1'b0;
    if (a > PI) begin
      a = PI;  e.sat = 1'b1;
    end else if (a < -PI) begin
      a = -PI; e.sat = 1'b1;
    end
    r   = real'(a) / SCALE;
    e.c = longint'($cos(r) * SCALE);
    e.s = longint'($sin(r) * SCALE);
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp,
                       input longint tol);
    n_checks++;
    if (act > exp + tol || act < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
    end
  endtask

  function automatic longint rand_angle();
    longint b;
    case ($urandom_range(0, 3))
      0: return longint'($urandom()) + longint'($urandom_range(0, 1)) * 64'sd4294967296
                - 64'sd4294967296;
      1: return longint'($urandom_range(0, 32'd3373259426));
      2: return -longint'($urandom_range(0, 32'd3373259426));
      default: begin
        case ($urandom_range(0, 3))
          0: b = PI;
          1: b = -PI;
          2: b = HALF_PI;
          default: b = -HALF_PI;
        endcase
        return b + longint'($urandom_range(0, 4)) - 64'sd2;
      end
    endcase
  endfunction

  // Record the expected response of every accepted request
  always @(negedge i_clk) begin
    if (i_rst_n && s_valid && s_ready) exp_q.push_back(ref_model(longint'(s_angle)));
  end

  // Compare every output handshake with the oldest expected response
  always @(negedge i_clk) begin
    if (i_rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: cos %0d sin %0d with nothing outstanding", m_cos, m_sin);
      end else begin
        mon_e = exp_q.pop_front();
        check("m_cos", longint'(m_cos), mon_e.c, TOL);
        check("m_sin", longint'(m_sin), mon_e.s, TOL);
        check("m_sat", longint'(m_sat), longint'(mon_e.sat), 0);
        n_results++;
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1)
  task automatic send(input longint ang);
    int w;
    w       = 0;
    s_valid = 1'b1;
    s_angle = BITS'(ang);
    @(negedge i_clk);
    while (!s_ready && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    if (!s_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: s_ready stayed 0, required 1");
    end
    @(posedge i_clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_z(input string nm, input longint ang, input longint exp_z);
    send(ang);
    @(negedge i_clk);
    check({nm, "_cvalid"}, longint'(c_valid), 1, 0);
    check({nm, "_cz"}, longint'(c_z), exp_z, 0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain(input string nm);
    m_ready = 1'b1;
    repeat (40) @(posedge i_clk);
    #1;
    check({nm, "_queue_left"}, longint'(exp_q.size()), 0, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_s_ready"}, longint'(s_ready), 1, 0);
    check({nm, "_c_valid"}, longint'(c_valid), 0, 0);
    check({nm, "_c_z"},     longint'(c_z), 0, 0);
    check({nm, "_m_valid"}, longint'(m_valid), 0, 0);
    check({nm, "_m_cos"},   longint'(m_cos), 0, 0);
    check({nm, "_m_sin"},   longint'(m_sin), 0, 0);
    check({nm, "_m_sat"},   longint'(m_sat), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int     first;
    int     cv_cnt;
    int     acc;
    int     mv;
    int     res_before;
    bit     adv;
    bit     last_acc;

    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("reset");
    check("c_mode", longint'(c_mode), 1, 0);
    check("c_rot_en", longint'(c_rot_en), 1, 0);

    // Latency: pi/3 accepted at edge 0, m_valid first seen in cycle 15
    @(posedge i_clk);
    #1;
    m_ready = 1'b1;
    send(64'sd1124419809);
    first  = -1;
    cv_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge i_clk);
      if (cyc == 1) check("pi3_cz", longint'(c_z), 64'sd1124419809, 0);
      if (c_valid) cv_cnt++;
      if (m_valid && first < 0) first = cyc;
    end
    check("c_valid_pulses", longint'(cv_cnt), 1, 0);
    check("m_valid_latency", longint'(first), 15, 0);

    // Fold and clamp boundaries
    @(posedge i_clk);
    #1;
    send_z("fold_2pi3",   64'sd2248839619,  -64'sd1124419807);
    send_z("half_pi",     64'sd1686629713,   64'sd1686629713);
    send_z("neg_half_pi", -64'sd1686629713, -64'sd1686629713);
    send_z("half_pi_p1",  64'sd1686629714,  -64'sd1686629712);
    send_z("clamp_pos",   64'sd3758096384,   64'sd0);
    send_z("clamp_neg",   -64'sd3758096384,  64'sd0);
    send_z("pi",          64'sd3373259426,   64'sd0);
    drain("directed");

    // Backpressure: 20 back-to-back requests with the consumer stalled
    m_ready = 1'b0;
    acc     = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_angle = BITS'(rand_angle());
      @(negedge i_clk);
      if (s_ready) acc++;
      @(posedge i_clk);
      #1;
    end
    s_valid = 1'b0;
    check("bp_accepted", longint'(acc), 16, 0);
    @(negedge i_clk);
    check("bp_s_ready_low", longint'(s_ready), 0, 0);
    repeat (20) @(posedge i_clk);
    #1;

    // First pop frees a credit; s_ready returns the following cycle, then
    // accepts and pops coincide while credits sit at the boundary
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_angle = BITS'(rand_angle());
    @(negedge i_clk);
    check("pop_cycle_m_valid", longint'(m_valid), 1, 0);
    check("pop_cycle_s_ready", longint'(s_ready), 0, 0);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check("after_pop_s_ready", longint'(s_ready), 1, 0);
    adv = s_ready;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk);
      #1;
      if (adv) s_angle = BITS'(rand_angle());
      @(negedge i_clk);
      adv = s_ready;
    end
    @(posedge i_clk);
    #1;
    s_valid = 1'b0;
    drain("stream");
    check("stream_results", longint'(n_results), 1 + 7 + 16 + 41, 0);

    // Random traffic with random consumer stalls
    last_acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge i_clk);
      #1;
      if (!s_valid || last_acc) begin
        s_valid = ($urandom_range(0, 9) < 7);
        s_angle = BITS'(rand_angle());
      end
      m_ready = ($urandom_range(0, 9) < 6);
      @(negedge i_clk);
      last_acc = s_valid && s_ready;
    end
    @(posedge i_clk);
    #1;
    s_valid = 1'b0;
    drain("random");

    // Reset with five requests in flight
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_angle = BITS'(rand_angle());
      @(posedge i_clk);
      #1;
    end
    s_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    mv = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (m_valid) mv++;
    end
    check("post_reset_m_valid", longint'(mv), 0, 0);
    @(posedge i_clk);
    #1;
    res_before = n_results;
    send(64'sd1124419809);
    drain("post_reset");
    check("post_reset_result", longint'(n_results - res_before), 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
